// File: rtl/ss_chunk_pkg.sv
// rtl/ss_chunk_pkg.sv - save-state chunk bus shared types, header layout and helpers
//
// Purpose: definitions shared by the chunk responder and the streamer.
//   width_e      element width code (0=8b, 1=16b, 2=32b, 3=64b)
//   *_LSB        bit positions of the header fields
//   header_pack  builds the 64-bit chunk header word
//   width_mask   64-bit mask selecting the valid bits of one element
package ss_chunk_pkg;

  typedef enum logic [1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_32 = 2'd2,
    WIDTH_64 = 2'd3
  } width_e;

  localparam int unsigned SIZE_LSB  = 0;
  localparam int unsigned WIDTH_LSB = 32;
  localparam int unsigned ID_LSB    = 56;

  // Header: [31:0] size, [33:32] width code, [63:56] chunk id, rest zero.
  function automatic logic [63:0] header_pack(input logic [7:0]  id,
                                              input width_e      width,
                                              input logic [31:0] size);
    logic [63:0] h;
    h = '0;
    h[SIZE_LSB  +: 32] = size;
    h[WIDTH_LSB +: 2]  = width;
    h[ID_LSB    +: 8]  = id;
    return h;
  endfunction

  function automatic logic [63:0] width_mask(input width_e width);
    logic [63:0] m;
    case (width)
      WIDTH_8:  m = 64'h0000_0000_0000_00FF;
      WIDTH_16: m = 64'h0000_0000_0000_FFFF;
      WIDTH_32: m = 64'h0000_0000_FFFF_FFFF;
      default:  m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ss_chunk_responder.sv
// rtl/ss_chunk_responder.sv - save-state chunk bus target endpoint for one chunk
//
// Purpose: answers query (header), gather (read) and scatter (write) requests
// addressed to CHUNK_ID, turning element-indexed requests into single accesses
// on a local memory port. read_data/data_ack are zero unless this instance is
// acknowledging, so several instances can be OR-combined on the shared bus.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   query_req             header phase qualifier
//   read_req / write_req  gather / scatter request (exactly one must be high)
//   chunk_select          chunk index, compared against CHUNK_ID
//   chunk_address         element index within the chunk
//   write_data            scatter element or offered header
//   read_data, data_ack   response word and one-cycle acknowledge
//   mem_addr/rd/wr/wdata  local memory request, strobes held until mem_ready
//   mem_rdata, mem_ready  local memory response
//   busy                  FSM not idle
module ss_chunk_responder
  import ss_chunk_pkg::*;
#(
  parameter int unsigned CHUNK_ID = 0,
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned WIDTH    = 0,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              query_req,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [7:0]        chunk_select,
  input  logic [31:0]       chunk_address,
  input  logic [63:0]       write_data,
  output logic [63:0]       read_data,
  output logic              data_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_RD  = 3'd1,
    MEM_WR  = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [7:0]  ID8    = CHUNK_ID[7:0];
  localparam logic [31:0] SIZE32 = SIZE[31:0];
  localparam width_e      WCODE  = width_e'(WIDTH[1:0]);
  localparam logic [63:0] HEADER = header_pack(ID8, WCODE, SIZE32);
  localparam logic [63:0] MASK   = width_mask(WCODE);

  state_e              state_q, state_d;
  logic [63:0]         read_data_q, read_data_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic                abort_q, abort_d;

  logic sel;
  logic take;
  logic in_range;
  logic hdr_match;

  assign sel       = (chunk_select == ID8);
  // Both request lines high at once is not a valid request and is ignored.
  assign take      = sel & (read_req ^ write_req);
  assign in_range  = (chunk_address < SIZE32);
  assign hdr_match = (write_data[31:0] == SIZE32) && (write_data[33:32] == WCODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    abort_d     = abort_q;

    case (state_q)
      IDLE: begin
        read_data_d = '0;
        abort_d     = 1'b0;
        if (take) begin
          if (query_req) begin
            if (read_req) begin
              read_data_d = HEADER;
              state_d     = ACK;
            end else if (hdr_match) begin
              state_d = ACK;
            end else begin
              // Header mismatch: stay silent so the initiator times out.
              state_d = RELEASE;
            end
          end else if (!in_range) begin
            // Out-of-range gather returns zero; out-of-range scatter is dropped.
            state_d = ACK;
          end else if (read_req) begin
            mem_addr_d = chunk_address[ADDR_W-1:0];
            mem_rd_d   = 1'b1;
            state_d    = MEM_RD;
          end else begin
            mem_addr_d  = chunk_address[ADDR_W-1:0];
            mem_wdata_d = write_data & MASK;
            mem_wr_d    = 1'b1;
            state_d     = MEM_WR;
          end
        end
      end

      MEM_RD: begin
        // A dropped request is remembered; the access still completes.
        if (!read_req) abort_d = 1'b1;
        if (mem_ready) begin
          mem_rd_d    = 1'b0;
          read_data_d = mem_rdata & MASK;
          state_d     = abort_d ? RELEASE : ACK;
        end
      end

      MEM_WR: begin
        if (!write_req) abort_d = 1'b1;
        if (mem_ready) begin
          mem_wr_d = 1'b0;
          state_d  = abort_d ? RELEASE : ACK;
        end
      end

      ACK: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        read_data_d = '0;
        // Wait for the initiator to drop its request so each request acks once.
        if (!read_req && !write_req) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_ack  = (state_q == ACK);
  assign read_data = data_ack ? read_data_q : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ss_chunk_responder.sv
// tb/tb_ss_chunk_responder.sv - scoreboard bench for ss_chunk_responder
module tb_ss_chunk_responder;

  localparam int CID = 3;
  localparam int SZ  = 16;
  localparam int WD  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        query_req = 1'b0, read_req = 1'b0, write_req = 1'b0;
  logic [7:0]  chunk_select = '0;
  logic [31:0] chunk_address = '0;
  logic [63:0] write_data = '0;
  logic [63:0] read_data;
  logic        data_ack;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  ss_chunk_responder #(.CHUNK_ID(CID), .SIZE(SZ), .WIDTH(WD), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .query_req(query_req), .read_req(read_req), .write_req(write_req),
    .chunk_select(chunk_select), .chunk_address(chunk_address),
    .write_data(write_data), .read_data(read_data), .data_ack(data_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural reference: header and element width from the chunk rules.
  logic [63:0] elem_mod;
  logic [63:0] ref_mem [0:15];

  function automatic logic [63:0] ref_header();
    return 64'(CID) * (64'd1 << 56) + 64'(WD) * (64'd1 << 32) + 64'(SZ);
  endfunction

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  logic [63:0] ack_q [$];
  mem_exp_t    mem_q [$];

  // Memory device: fixed-latency ready, stores writes.
  int          lat = 3;
  int          hold = 0;
  logic [63:0] dev_mem [0:15];
  logic [63:0] load_val [0:15];
  logic        mem_load = 1'b0;

  assign mem_ready = (mem_rd || mem_wr) && (hold == lat - 1);
  assign mem_rdata = dev_mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) hold <= hold + 1;
    else hold <= 0;
    if (mem_load) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= load_val[i];
    end else if (mem_wr && mem_ready) begin
      dev_mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acks or completes an access.
  initial begin
    logic [63:0] e;
    mem_exp_t    m;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_ack) begin
          tests++;
          if (ack_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ack: data_ack=1 read_data=%h, required no ack", read_data);
          end else begin
            e = ack_q.pop_front();
            if (read_data !== e) begin
              fails++;
              $display("FAIL ack_data: read_data=%h, required %h", read_data, e);
            end
          end
        end else if (read_data !== 64'd0) begin
          tests++; fails++;
          $display("FAIL idle_read_data: read_data=%h without ack, required 0", read_data);
        end
        if (mem_rd && mem_wr) begin
          tests++; fails++;
          $display("FAIL mem_strobes: mem_rd=1 and mem_wr=1 together, required at most one");
        end
        if ((mem_rd || mem_wr) && mem_ready) begin
          tests++;
          if (mem_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_mem: wr=%0d addr=%0d, required no access", mem_wr, mem_addr);
          end else begin
            m = mem_q.pop_front();
            if (mem_wr !== m.wr || mem_addr !== m.addr || (m.wr && mem_wdata !== m.wdata)) begin
              fails++;
              $display("FAIL mem_access: wr=%0d addr=%0d wdata=%h, required wr=%0d addr=%0d wdata=%h",
                       mem_wr, mem_addr, mem_wdata, m.wr, m.addr, m.wdata);
            end
          end
        end
      end
    end
  end

  // Initiator: raise a request, wait for ack (bounded) or a silent window, then drop.
  task automatic do_req(input bit q, input bit rd, input bit wr, input logic [7:0] sel,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input bit exp_ack, input int exp_lat, input int hold_after,
                        input bit chk_idle);
    int n;
    bit got;
    @(posedge clk); #1;
    query_req = q; read_req = rd; write_req = wr;
    chunk_select = sel; chunk_address = addr; write_data = wd;
    if (exp_ack) begin
      n = 0; got = 1'b0;
      while (!got && n < 60) begin
        @(negedge clk);
        n++;
        got = data_ack;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL ack_timeout: no data_ack after %0d cycles, required one", n);
      end else if (exp_lat > 0 && n != exp_lat) begin
        fails++;
        $display("FAIL ack_latency: ack at cycle %0d, required %0d", n, exp_lat);
      end
      repeat (hold_after) @(posedge clk);
    end else begin
      repeat (16) @(negedge clk);
    end
    @(posedge clk); #1;
    query_req = 1'b0; read_req = 1'b0; write_req = 1'b0;
    if (chk_idle) begin
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_idle: busy=%0d after req dropped, required 0", busy);
      end
    end
  endtask

  task automatic wait_mem_strobe(input string name);
    int n;
    n = 0;
    while (!(mem_rd || mem_wr) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_rd || mem_wr)) begin
      tests++; fails++;
      $display("FAIL %s: no memory strobe within 10 cycles, required one", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int          kind, h, n;
    bit          ci, q, rd, wr;
    logic [31:0] a;
    logic [63:0] w;
    logic [7:0]  s;

    elem_mod = 64'd1 << (8 << WD);
    for (int i = 0; i < 16; i++) begin
      load_val[i] = 64'hFFFF_FFFF_0000_ABCD;
      ref_mem[i]  = 64'hFFFF_FFFF_0000_ABCD;
    end
    mem_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_load = 1'b0;

    @(negedge clk);
    tests++;
    if ({read_data, data_ack, mem_addr, mem_rd, mem_wr, mem_wdata, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rd=%h ack=%0d addr=%0d mrd=%0d mwr=%0d wdata=%h busy=%0d, required all 0",
               read_data, data_ack, mem_addr, mem_rd, mem_wr, mem_wdata, busy);
    end
    @(posedge clk); #1 reset = 1'b0;

    // Header read, known word.
    ack_q.push_back(64'h0300_0001_0000_0010);
    do_req(1, 1, 0, 8'd3, 32'd0, 64'd0, 1, 2, 0, 1);
    // Unselected header read and gather: silent, no memory access.
    do_req(1, 1, 0, 8'd2, 32'd0, 64'd0, 0, 0, 0, 1);
    do_req(0, 1, 0, 8'd2, 32'd4, 64'd0, 0, 0, 0, 1);
    // Header offer: matching acks, size 0x11 stays silent.
    ack_q.push_back(64'd0);
    do_req(1, 0, 1, 8'd3, 32'd0, 64'h0300_0001_0000_0010, 1, 2, 0, 1);
    do_req(1, 0, 1, 8'd3, 32'd0, 64'h0300_0001_0000_0011, 0, 0, 0, 1);

    // Gather 0..15 with ready latency 3.
    lat = 3;
    for (int i = 0; i < 16; i++) begin
      ack_q.push_back(ref_mem[i] % elem_mod);
      mem_q.push_back('{1'b0, 16'(i), 64'd0});
      do_req(0, 1, 0, 8'd3, 32'(i), 64'd0, 1, 5, 1, 0);
    end

    // Scatter in range and at the boundary.
    mem_q.push_back('{1'b1, 16'd5, 64'h5678});
    ref_mem[5] = 64'h5678;
    ack_q.push_back(64'd0);
    do_req(0, 0, 1, 8'd3, 32'd5, 64'h1234_5678, 1, 5, 0, 1);
    ack_q.push_back(64'd0);
    do_req(0, 0, 1, 8'd3, 32'd16, 64'h1234_5678, 1, 2, 0, 1);

    // Initiator abort during MEM_RD: access completes, no ack.
    lat = 6;
    mem_q.push_back('{1'b0, 16'd7, 64'd0});
    @(posedge clk); #1;
    chunk_select = 8'd3; chunk_address = 32'd7; read_req = 1'b1;
    wait_mem_strobe("abort_strobe");
    @(posedge clk); #1 read_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0 || mem_q.size() != 0) begin
      fails++;
      $display("FAIL abort_finish: busy=%0d pending_mem=%0d, required 0 and 0", busy, mem_q.size());
    end

    // Reset in the middle of a read access.
    lat = 20;
    @(posedge clk); #1;
    chunk_select = 8'd3; chunk_address = 32'd2; read_req = 1'b1;
    wait_mem_strobe("reset_strobe");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem_rd !== 1'b0 || data_ack !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_midaccess: mem_rd=%0d data_ack=%0d busy=%0d, required 0 0 0", mem_rd, data_ack, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0; read_req = 1'b0;
    ack_q.push_back(ref_header());
    do_req(1, 1, 0, 8'd3, 32'd0, 64'd0, 1, 2, 0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      load_val[i] = {$urandom, $urandom};
      ref_mem[i]  = load_val[i] % elem_mod;
      load_val[i] = ref_mem[i] | (load_val[i] & ~(elem_mod - 64'd1)) ;
    end
    @(posedge clk); #1 mem_load = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 8);
      h    = $urandom_range(0, 2);
      ci   = 1'($urandom_range(0, 1));
      lat  = $urandom_range(1, 4);
      w    = {$urandom, $urandom};
      case (kind)
        0: begin
          ack_q.push_back(ref_header());
          do_req(1, 1, 0, 8'(CID), $urandom, w, 1, 2, h, ci);
        end
        1: begin
          w = (w & ~((64'd1 << 34) - 64'd1)) + 64'(WD) * (64'd1 << 32) + 64'(SZ);
          ack_q.push_back(64'd0);
          do_req(1, 0, 1, 8'(CID), $urandom, w, 1, 2, h, ci);
        end
        2: begin
          if (w % (64'd1 << 34) == 64'(WD) * (64'd1 << 32) + 64'(SZ)) w = w ^ 64'd1;
          do_req(1, 0, 1, 8'(CID), $urandom, w, 0, 0, 0, 1);
        end
        3: begin
          a = $urandom_range(0, SZ - 1);
          ack_q.push_back(ref_mem[a]);
          mem_q.push_back('{1'b0, 16'(a), 64'd0});
          do_req(0, 1, 0, 8'(CID), a, w, 1, 2 + lat, h, ci);
        end
        4: begin
          a = $urandom_range(SZ, 32'hFFFF_FFFF);
          ack_q.push_back(64'd0);
          do_req(0, 1, 0, 8'(CID), a, w, 1, 2, h, ci);
        end
        5: begin
          a = $urandom_range(0, SZ - 1);
          mem_q.push_back('{1'b1, 16'(a), w % elem_mod});
          ref_mem[a] = w % elem_mod;
          ack_q.push_back(64'd0);
          do_req(0, 0, 1, 8'(CID), a, w, 1, 2 + lat, h, ci);
        end
        6: begin
          a = $urandom_range(SZ, 32'hFFFF_FFFF);
          ack_q.push_back(64'd0);
          do_req(0, 0, 1, 8'(CID), a, w, 1, 2, h, ci);
        end
        7: begin
          s = 8'($urandom_range(0, 255));
          if (s == 8'(CID)) s = s + 8'd1;
          q  = 1'($urandom_range(0, 1));
          rd = 1'($urandom_range(0, 1));
          wr = ~rd;
          do_req(q, rd, wr, s, $urandom_range(0, SZ - 1), w, 0, 0, 0, 1);
        end
        default: begin
          q = 1'($urandom_range(0, 1));
          do_req(q, 1, 1, 8'(CID), $urandom_range(0, SZ - 1), w, 0, 0, 0, 1);
        end
      endcase
    end

    repeat (5) @(negedge clk);
    tests++;
    if (ack_q.size() != 0 || mem_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending acks=%0d mem=%0d, required 0 and 0", ack_q.size(), mem_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
